// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller
// ----------------------------------------------------------------------------
// Control unit of the tinymips multicycle datapath.
//
// A Moore FSM steps each instruction through the fetch, decode, execute,
// memory and writeback phases. It drives the datapath mux selects and the
// write enables. An embedded ALU decoder turns the phase's ALU operation
// class plus the instruction funct field into the 3-bit alucontrol code.
//
// Ports
//   clk         in   1  system clock, rising edge
//   reset_n     in   1  asynchronous active-low reset
//   op          in   6  instr[31:26] from the instruction register
//   funct       in   6  instr[5:0] from the instruction register
//   zero        in   1  ALU zero flag (used in the branch states)
//   iord        out  1  memory address select: 0=PC, 1=ALUOut
//   memwrite    out  1  data memory write enable
//   irwrite     out  1  instruction register load enable
//   regwrite    out  1  register file write enable
//   regdst      out  1  destination register: 0=rt, 1=rd
//   memtoreg    out  1  writeback data: 0=ALUOut, 1=memory data
//   alusrca     out  1  ALU A: 0=PC, 1=rs
//   alusrcb     out  2  ALU B: 00=rt, 01=4, 10=signimm, 11=signimm<<2
//   pcsrc       out  2  next PC: 00=ALUResult, 01=ALUOut, 10=jump target
//   pcen        out  1  PC load enable
//   alucontrol  out  3  ALU operation code
//   state       out  4  current FSM state (monitor/debug)
//
// Configuration
//   TINYMIPS_BNE_EN : when defined, adds bne (op 000101) through state
//                     BNEEX (12). When undefined, bne decodes as an unknown
//                     opcode and acts as a NOP.
// ============================================================================
module multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    // ------------------------------------------------------------------
    // Opcode and funct encodings (MIPS subset)
    // ------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // ALU operation class chosen by each state; the ALU decoder refines it.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_NONE = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // BNEEX is always part of the type. It is only reachable when
    // TINYMIPS_BNE_EN is defined.
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } state_e;

    state_e     state_q;
    state_e     state_d;

    // Raw per-state controls, before reset gating and ALU decoding
    logic       pcWrite;
    logic       branchEq;
    logic       branchNe;
    logic       irWriteRaw;
    logic       regWriteRaw;
    logic       memWriteRaw;
    logic [1:0] aluOp;

    // ------------------------------------------------------------------
    // State register: the only sequential element in the block
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW,
                    OP_SW:    state_d = MEMADR;
                    OP_RTYPE: state_d = RTYPEEX;
                    OP_BEQ:   state_d = BEQEX;
                    OP_ADDI:  state_d = ADDIEX;
                    OP_J:     state_d = JEX;
`ifdef TINYMIPS_BNE_EN
                    OP_BNE:   state_d = BNEEX;
`endif
                    // Unknown opcodes retire as a NOP with no writes.
                    default:  state_d = FETCH;
                endcase
            end
            // Only lw and sw reach MEMADR, so anything that is not sw is lw.
            MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            // Writeback, branch and jump states, plus unused encodings,
            // all return to FETCH.
            default: state_d = FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs: every control defaults to 0 (ALU op = add)
    // ------------------------------------------------------------------
    always_comb begin
        iord        = 1'b0;
        memWriteRaw = 1'b0;
        irWriteRaw  = 1'b0;
        regWriteRaw = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        pcWrite     = 1'b0;
        branchEq    = 1'b0;
        branchNe    = 1'b0;
        aluOp       = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                irWriteRaw = 1'b1;
                pcWrite    = 1'b1;
                alusrcb    = 2'b01;
            end
            DECODE: begin
                // Precompute the branch target into ALUOut.
                alusrcb = 2'b11;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                regWriteRaw = 1'b1;
                memtoreg    = 1'b1;
            end
            MEMWR: begin
                iord        = 1'b1;
                memWriteRaw = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluOp   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                regWriteRaw = 1'b1;
                regdst      = 1'b1;
            end
            BEQEX: begin
                alusrca  = 1'b1;
                aluOp    = ALUOP_SUB;
                branchEq = 1'b1;
                pcsrc    = 2'b01;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: begin
                regWriteRaw = 1'b1;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcWrite = 1'b1;
            end
`ifdef TINYMIPS_BNE_EN
            BNEEX: begin
                alusrca  = 1'b1;
                aluOp    = ALUOP_SUB;
                branchNe = 1'b1;
                pcsrc    = 2'b01;
            end
`endif
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU decoder
    // ------------------------------------------------------------------
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluOp)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    // ALU yields 0 for this code, so an unknown funct
                    // writes 0 to rd.
                    default: alucontrol = ALU_NONE;
                endcase
            end
            default:   alucontrol = ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Write enables are gated by reset_n. FETCH's enables therefore stay
    // quiet while reset is held, and its mux selects keep their values.
    // ------------------------------------------------------------------
    assign irwrite  = irWriteRaw  & reset_n;
    assign regwrite = regWriteRaw & reset_n;
    assign memwrite = memWriteRaw & reset_n;
    assign pcen     = (pcWrite | (branchEq & zero) | (branchNe & ~zero)) & reset_n;

    assign state    = state_q;

endmodule
